brent_kung_adder16: RTL and testbench

- 16-bit parallel-prefix adder using a Brent-Kung carry network.
- Computes Sum = a + b + Cin, with carry-out Cout.
- The adder core is combinational; Sum and Cout are registered once on clk.
- Used as an arithmetic building block wherever a low-fanout, log-depth 16-bit adder is needed.

---
 rtl/bk_pkg.sv | 8 +
 rtl/bk_cell.sv | 14 +
 rtl/brent_kung_adder16.sv | 152 +++++++++++++++
 tb/tb_brent_kung_adder16.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared width and word type for the 16-bit Brent-Kung adder.
package bk_pkg;

    localparam int W = 16;

    typedef logic [W-1:0] word_t;

endpackage

// File: rtl/bk_cell.sv
// Brent-Kung prefix black cell; use it as a grey cell by leaving po unread.
module bk_cell (
    input  logic gi,
    input  logic pi,
    input  logic gk,
    input  logic pk,
    output logic go,
    output logic po
);

    assign go = gi | (pi & gk);
    assign po = pi & pk;

endmodule

// File: rtl/brent_kung_adder16.sv
// 16-bit Brent-Kung parallel-prefix adder with a single output register stage.
// pre[i] holds the group generate G[i:0] with Cin already folded into bit 0.
module brent_kung_adder16
    import bk_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         Cin,
    output logic [W-1:0] Sum,
    output logic         Cout
);

    word_t g;
    word_t p;
    word_t gl0;

    logic [7:0]  g_l1;
    logic [7:1]  p_l1;
    logic [3:0]  g_l2;
    logic [3:1]  p_l2;
    logic [1:0]  g_l3;
    logic        p_l3;

    word_t       pre;
    word_t       carry;
    word_t       sum_c;

    // Cells anchored at bit 0 only need G; their pk is tied low and po dropped.
    logic [14:0] grey_po_unused;

    assign g   = a & b;
    assign p   = a ^ b;
    assign gl0 = {g[W-1:1], g[0] | (p[0] & Cin)};

    // Up-sweep, level 1: spans [2j+1:2j]
    bk_cell u_l1_0 (
        .gi(gl0[1]),  .pi(p[1]),  .gk(gl0[0]),  .pk(1'b0),
        .go(g_l1[0]), .po(grey_po_unused[0])
    );
    bk_cell u_l1_1 (
        .gi(gl0[3]),  .pi(p[3]),  .gk(gl0[2]),  .pk(p[2]),
        .go(g_l1[1]), .po(p_l1[1])
    );
    bk_cell u_l1_2 (
        .gi(gl0[5]),  .pi(p[5]),  .gk(gl0[4]),  .pk(p[4]),
        .go(g_l1[2]), .po(p_l1[2])
    );
    bk_cell u_l1_3 (
        .gi(gl0[7]),  .pi(p[7]),  .gk(gl0[6]),  .pk(p[6]),
        .go(g_l1[3]), .po(p_l1[3])
    );
    bk_cell u_l1_4 (
        .gi(gl0[9]),  .pi(p[9]),  .gk(gl0[8]),  .pk(p[8]),
        .go(g_l1[4]), .po(p_l1[4])
    );
    bk_cell u_l1_5 (
        .gi(gl0[11]), .pi(p[11]), .gk(gl0[10]), .pk(p[10]),
        .go(g_l1[5]), .po(p_l1[5])
    );
    bk_cell u_l1_6 (
        .gi(gl0[13]), .pi(p[13]), .gk(gl0[12]), .pk(p[12]),
        .go(g_l1[6]), .po(p_l1[6])
    );
    bk_cell u_l1_7 (
        .gi(gl0[15]), .pi(p[15]), .gk(gl0[14]), .pk(p[14]),
        .go(g_l1[7]), .po(p_l1[7])
    );

    // Level 2: spans [4j+3:4j]
    bk_cell u_l2_0 (
        .gi(g_l1[1]), .pi(p_l1[1]), .gk(g_l1[0]), .pk(1'b0),
        .go(g_l2[0]), .po(grey_po_unused[1])
    );
    bk_cell u_l2_1 (
        .gi(g_l1[3]), .pi(p_l1[3]), .gk(g_l1[2]), .pk(p_l1[2]),
        .go(g_l2[1]), .po(p_l2[1])
    );
    bk_cell u_l2_2 (
        .gi(g_l1[5]), .pi(p_l1[5]), .gk(g_l1[4]), .pk(p_l1[4]),
        .go(g_l2[2]), .po(p_l2[2])
    );
    bk_cell u_l2_3 (
        .gi(g_l1[7]), .pi(p_l1[7]), .gk(g_l1[6]), .pk(p_l1[6]),
        .go(g_l2[3]), .po(p_l2[3])
    );

    // Level 3: spans [7:0] and [15:8]
    bk_cell u_l3_0 (
        .gi(g_l2[1]), .pi(p_l2[1]), .gk(g_l2[0]), .pk(1'b0),
        .go(g_l3[0]), .po(grey_po_unused[2])
    );
    bk_cell u_l3_1 (
        .gi(g_l2[3]), .pi(p_l2[3]), .gk(g_l2[2]), .pk(p_l2[2]),
        .go(g_l3[1]), .po(p_l3)
    );

    // Level 4: [15:0], which is also the carry-out
    bk_cell u_l4_0 (
        .gi(g_l3[1]), .pi(p_l3), .gk(g_l3[0]), .pk(1'b0),
        .go(pre[15]), .po(grey_po_unused[3])
    );

    // Down-sweep, level 5: [11:0]
    bk_cell u_l5_0 (
        .gi(g_l2[2]), .pi(p_l2[2]), .gk(g_l3[0]), .pk(1'b0),
        .go(pre[11]), .po(grey_po_unused[4])
    );

    // Level 6: [5:0] [9:0] [13:0]
    bk_cell u_l6_0 (
        .gi(g_l1[2]), .pi(p_l1[2]), .gk(g_l2[0]), .pk(1'b0),
        .go(pre[5]),  .po(grey_po_unused[5])
    );
    bk_cell u_l6_1 (
        .gi(g_l1[4]), .pi(p_l1[4]), .gk(g_l3[0]), .pk(1'b0),
        .go(pre[9]),  .po(grey_po_unused[6])
    );
    bk_cell u_l6_2 (
        .gi(g_l1[6]), .pi(p_l1[6]), .gk(pre[11]), .pk(1'b0),
        .go(pre[13]), .po(grey_po_unused[7])
    );

    // Level 7: every even prefix [2k:0] from the odd prefix just below it
    for (genvar k = 1; k < 8; k++) begin : g_l7
        bk_cell u_l7 (
            .gi(gl0[2*k]),   .pi(p[2*k]),
            .gk(pre[2*k-1]), .pk(1'b0),
            .go(pre[2*k]),   .po(grey_po_unused[7+k])
        );
    end

    assign pre[0] = gl0[0];
    assign pre[1] = g_l1[0];
    assign pre[3] = g_l2[0];
    assign pre[7] = g_l3[0];

    assign carry = {pre[W-2:0], Cin};
    assign sum_c = p ^ carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_c;
            Cout <= pre[W-1];
        end
    end

endmodule

// File: tb/tb_brent_kung_adder16.sv
// Directed table plus reset/streaming sequences and random vectors for brent_kung_adder16.
module tb_brent_kung_adder16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        Cin;
    logic [15:0] Sum;
    logic        Cout;

    int          nvec;
    int          nfail;
    vec_t        vecs[$];

    brent_kung_adder16 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .Cin (Cin),
        .Sum (Sum),
        .Cout(Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                input logic [15:0] es, input logic ec);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.exp_sum = es; v.exp_cout = ec;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a   = va;
        b   = vb;
        Cin = vc;
    endtask

    task automatic check(input string name, input logic [15:0] es, input logic ec);
        nvec++;
        if (Sum !== es || Cout !== ec) begin
            nfail++;
            $display("FAIL %s: got Sum=%h Cout=%b, expected Sum=%h Cout=%b",
                     name, Sum, Cout, es, ec);
        end
    endtask

    initial begin
        logic [16:0] exp17;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        nvec  = 0;
        nfail = 0;

        add(16'd20,    16'd87,    1'b1, 16'd108,   1'b0);
        add(16'd280,   16'd361,   1'b1, 16'd642,   1'b0);
        add(16'd2000,  16'd5000,  1'b1, 16'd7001,  1'b0);
        add(16'd6400,  16'd21000, 1'b0, 16'd27400, 1'b0);
        add(16'd750,   16'd361,   1'b0, 16'd1111,  1'b0);
        add(16'd25000, 16'd4801,  1'b0, 16'd29801, 1'b0);
        add(16'd3150,  16'd5800,  1'b1, 16'd8951,  1'b0);
        add(16'd7,     16'd6,     1'b1, 16'd14,    1'b0);
        add(16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1);
        add(16'hFFFF,  16'h0000,  1'b0, 16'hFFFF,  1'b0);
        add(16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1);
        add(16'h00FF,  16'h0001,  1'b0, 16'h0100,  1'b0);
        add(16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1);
        add(16'h0000,  16'h0000,  1'b0, 16'h0000,  1'b0);
        add(16'h0000,  16'h0000,  1'b1, 16'h0001,  1'b0);
        add(16'hAAAA,  16'h5555,  1'b0, 16'hFFFF,  1'b0);
        add(16'hAAAA,  16'h5555,  1'b1, 16'h0000,  1'b1);
        add(16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0);
        add(16'h0FFF,  16'h0001,  1'b0, 16'h1000,  1'b0);
        add(16'h3FFF,  16'h0001,  1'b0, 16'h4000,  1'b0);
        add(16'h01FF,  16'h0001,  1'b0, 16'h0200,  1'b0);
        add(16'h003F,  16'h0001,  1'b0, 16'h0040,  1'b0);
        add(16'h0007,  16'h0000,  1'b1, 16'h0008,  1'b0);
        add(16'h1234,  16'h4321,  1'b0, 16'h5555,  1'b0);
        add(16'hF000,  16'h1000,  1'b0, 16'h0000,  1'b1);

        // Reset held with all-ones operands, then released
        rst = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        step();
        check("reset_cycle1", 16'h0000, 1'b0);
        step();
        check("reset_cycle2", 16'h0000, 1'b0);
        rst = 1'b0;
        step();
        check("reset_release", 16'hFFFF, 1'b1);

        // Table, one new operand set per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // One-cycle reset in the middle of a stream
        drive(16'd20, 16'd87, 1'b1);
        step();
        check("stream_pre", 16'd108, 1'b0);
        rst = 1'b1;
        drive(16'hFFFF, 16'h0000, 1'b1);
        step();
        check("stream_rst", 16'h0000, 1'b0);
        rst = 1'b0;
        drive(16'h8000, 16'h8000, 1'b0);
        step();
        check("stream_post", 16'h0000, 1'b1);
        drive(16'd7, 16'd6, 1'b1);
        step();
        check("stream_post2", 16'd14, 1'b0);

        // Mid-cycle input change: only the value present at the edge is captured
        drive(16'h1111, 16'h1111, 1'b0);
        #3;
        drive(16'h0F0F, 16'h00F1, 1'b1);
        step();
        check("midcycle", 16'h1001, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom_range(1, 0));
            exp17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            drive(ra, rb, rc);
            step();
            check($sformatf("rand%0d", i), exp17[15:0], exp17[16]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
